// File: rtl/sdiv_pkg.sv
// Shared widths, iteration count and controller state encoding for the sdiv block.
package sdiv_pkg;
    localparam int DIVIDEND_W = 16;
    localparam int DIVISOR_W  = 8;
    localparam int RESULT_W   = 8;
    localparam int ITER_COUNT = 16;
    localparam int CNT_W      = $clog2(ITER_COUNT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ITER,
        S_FIX,
        S_DONE,
        S_HOLD
    } state_t;
endpackage

// File: rtl/sdiv_datapath.sv
// Operand latches, restoring shift/subtract step, sign fix-up and sticky result flags.
// Steered entirely by the controller's load/init/step/commit strobes.
module sdiv_datapath
    import sdiv_pkg::*;
(
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  load_i,
    input  logic                  init_i,
    input  logic                  step_i,
    input  logic                  commit_i,
    input  logic [DIVIDEND_W-1:0] dividend_i,
    input  logic [DIVISOR_W-1:0]  divisor_i,
    output logic                  dvs_zero_o,
    output logic [RESULT_W-1:0]   quotient_o,
    output logic [RESULT_W-1:0]   remainder_o,
    output logic                  div_by_zero_o,
    output logic                  overflow_o
);
    logic [DIVIDEND_W-1:0] op_dvd_q;
    logic [DIVISOR_W-1:0]  op_dvs_q;
    logic [DIVIDEND_W-1:0] acc_q;
    logic [DIVISOR_W:0]    prem_q;
    logic [DIVISOR_W-1:0]  dvs_mag_q;
    logic                  qneg_q;
    logic                  rneg_q;
    logic [RESULT_W-1:0]   quo_q;
    logic [RESULT_W-1:0]   rem_q;
    logic                  dbz_q;
    logic                  ovf_q;

    logic [DIVISOR_W:0]    shifted_d;
    logic [DIVISOR_W:0]    trial_d;
    logic [RESULT_W-1:0]   q_fix_d;
    logic [RESULT_W-1:0]   r_fix_d;
    logic                  ovf_d;

    always_comb begin
        shifted_d = {prem_q[DIVISOR_W-1:0], acc_q[DIVIDEND_W-1]};
        trial_d   = shifted_d - {1'b0, dvs_mag_q};
        // A negative result may reach magnitude 128; a positive one stops at 127.
        ovf_d     = qneg_q ? (acc_q > DIVIDEND_W'(128)) : (acc_q > DIVIDEND_W'(127));
        q_fix_d   = qneg_q ? (~acc_q[RESULT_W-1:0] + RESULT_W'(1)) : acc_q[RESULT_W-1:0];
        r_fix_d   = rneg_q ? (~prem_q[RESULT_W-1:0] + RESULT_W'(1)) : prem_q[RESULT_W-1:0];
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            op_dvd_q  <= '0;
            op_dvs_q  <= '0;
            acc_q     <= '0;
            prem_q    <= '0;
            dvs_mag_q <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            dbz_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            if (load_i) begin
                op_dvd_q <= dividend_i;
                op_dvs_q <= divisor_i;
                dbz_q    <= 1'b0;
                ovf_q    <= 1'b0;
            end
            if (init_i) begin
                acc_q     <= op_dvd_q[DIVIDEND_W-1] ? (~op_dvd_q + DIVIDEND_W'(1)) : op_dvd_q;
                dvs_mag_q <= op_dvs_q[DIVISOR_W-1] ? (~op_dvs_q + DIVISOR_W'(1)) : op_dvs_q;
                prem_q    <= '0;
                qneg_q    <= op_dvd_q[DIVIDEND_W-1] ^ op_dvs_q[DIVISOR_W-1];
                rneg_q    <= op_dvd_q[DIVIDEND_W-1];
            end
            if (step_i) begin
                prem_q <= trial_d[DIVISOR_W] ? shifted_d : trial_d;
                acc_q  <= {acc_q[DIVIDEND_W-2:0], ~trial_d[DIVISOR_W]};
            end
            if (commit_i) begin
                if (op_dvs_q == '0) begin
                    quo_q <= '0;
                    rem_q <= '0;
                    dbz_q <= 1'b1;
                    ovf_q <= 1'b0;
                end else if (ovf_d) begin
                    quo_q <= {1'b1, {(RESULT_W-1){1'b0}}};
                    rem_q <= '0;
                    dbz_q <= 1'b0;
                    ovf_q <= 1'b1;
                end else begin
                    quo_q <= q_fix_d;
                    rem_q <= r_fix_d;
                    dbz_q <= 1'b0;
                    ovf_q <= 1'b0;
                end
            end
        end
    end

    assign dvs_zero_o    = (op_dvs_q == '0);
    assign quotient_o    = quo_q;
    assign remainder_o   = rem_q;
    assign div_by_zero_o = dbz_q;
    assign overflow_o    = ovf_q;
endmodule

// File: rtl/sdiv.sv
// Signed 16/8 restoring divider: controller FSM and iteration counter around sdiv_datapath.
// Nonzero divisor finishes in 19 cycles, zero divisor in 2; start is ignored while busy.
module sdiv
    import sdiv_pkg::*;
(
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [DIVIDEND_W-1:0] dividend_i,
    input  logic [DIVISOR_W-1:0]  divisor_i,
    output logic [RESULT_W-1:0]   quotient_o,
    output logic [RESULT_W-1:0]   remainder_o,
    output logic                  done_o,
    output logic                  busy_o,
    output logic                  div_by_zero_o,
    output logic                  overflow_o
);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load, init, step, commit;
    logic             dvs_zero;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        init    = 1'b0;
        step    = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    load    = 1'b1;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                init  = 1'b1;
                cnt_d = '0;
                if (dvs_zero) begin
                    commit  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                step  = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITER_COUNT - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                commit  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_HOLD;
            end
            S_HOLD: begin
                // A start still held from the previous request must drop first.
                if (!start_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign done_o = (state_q == S_DONE);
    assign busy_o = (state_q != S_IDLE);

    sdiv_datapath u_datapath (
        .clock_i       (clock_i),
        .reset_i       (reset_i),
        .load_i        (load),
        .init_i        (init),
        .step_i        (step),
        .commit_i      (commit),
        .dividend_i    (dividend_i),
        .divisor_i     (divisor_i),
        .dvs_zero_o    (dvs_zero),
        .quotient_o    (quotient_o),
        .remainder_o   (remainder_o),
        .div_by_zero_o (div_by_zero_o),
        .overflow_o    (overflow_o)
    );
endmodule

// File: tb/tb_sdiv.sv
// Directed-vector bench for sdiv: result table plus held-start, flag-clear and mid-op reset sequences.
module tb_sdiv;
    logic        clock;
    logic        reset;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        done;
    logic        busy;
    logic        div_by_zero;
    logic        overflow;

    int n_chk = 0;
    int n_bad = 0;

    sdiv dut (
        .clock_i       (clock),
        .reset_i       (reset),
        .start_i       (start),
        .dividend_i    (dividend),
        .divisor_i     (divisor),
        .quotient_o    (quotient),
        .remainder_o   (remainder),
        .done_o        (done),
        .busy_o        (busy),
        .div_by_zero_o (div_by_zero),
        .overflow_o    (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] dvd;
        logic [7:0]  dvs;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        dbz;
        logic        ovf;
        int          lat;
    } vec_t;

    vec_t vt[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Entered at a falling edge with the DUT idle; cycle 1 is the first falling edge after acceptance.
    task automatic run_op(input logic [15:0] dvd, input logic [7:0] dvs, output int lat,
                          output logic [7:0] q, output logic [7:0] r, output logic dbz, output logic ovf);
        lat = -1; q = 8'h00; r = 8'h00; dbz = 1'b0; ovf = 1'b0;
        dividend = dvd; divisor = dvs; start = 1'b1;
        @(negedge clock);
        start = 1'b0; dividend = ~dvd; divisor = ~dvs;
        for (int c = 1; c <= 60; c++) begin
            if (done) begin
                lat = c; q = quotient; r = remainder; dbz = div_by_zero; ovf = overflow;
                break;
            end
            @(negedge clock);
        end
        repeat (2) @(negedge clock);
    endtask

    int          lat;
    logic [7:0]  q, r;
    logic        dbz, ovf;
    int          pulses;

    initial begin
        vt[0]  = '{16'h0028, 8'hFB, 8'hF8, 8'h00, 1'b0, 1'b0, 19};
        vt[1]  = '{16'hFFD9, 8'h07, 8'hFB, 8'hFC, 1'b0, 1'b0, 19};
        vt[2]  = '{16'hFF80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 19};
        vt[3]  = '{16'h8000, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1, 19};
        vt[4]  = '{16'h1234, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 2};
        vt[5]  = '{16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 19};
        vt[6]  = '{16'hFF9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0, 19};
        vt[7]  = '{16'h7FFF, 8'h80, 8'h80, 8'h00, 1'b0, 1'b1, 19};
        vt[8]  = '{16'h3F80, 8'h80, 8'h81, 8'h00, 1'b0, 1'b0, 19};
        vt[9]  = '{16'h4000, 8'h80, 8'h80, 8'h00, 1'b0, 1'b0, 19};
        vt[10] = '{16'h0080, 8'h01, 8'h80, 8'h00, 1'b0, 1'b1, 19};
        vt[11] = '{16'hFF7F, 8'h01, 8'h80, 8'h00, 1'b0, 1'b1, 19};
        vt[12] = '{16'h007F, 8'h01, 8'h7F, 8'h00, 1'b0, 1'b0, 19};
        vt[13] = '{16'hFFFB, 8'h0A, 8'h00, 8'hFB, 1'b0, 1'b0, 19};
        vt[14] = '{16'h0000, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0, 19};
        vt[15] = '{16'h3F01, 8'h7F, 8'h7F, 8'h00, 1'b0, 1'b0, 19};
        vt[16] = '{16'h03EB, 8'h9C, 8'hF6, 8'h03, 1'b0, 1'b0, 19};

        reset = 1'b1; start = 1'b0; dividend = 16'h0000; divisor = 8'h00;
        repeat (3) @(negedge clock);
        chk("rst_quotient", {24'h0, quotient}, 32'h0);
        chk("rst_remainder", {24'h0, remainder}, 32'h0);
        chk("rst_ctrl", {28'h0, done, busy, div_by_zero, overflow}, 32'h0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 17; i++) begin
            run_op(vt[i].dvd, vt[i].dvs, lat, q, r, dbz, ovf);
            chk($sformatf("v%0d_latency", i), lat, vt[i].lat);
            chk($sformatf("v%0d_quotient", i), {24'h0, q}, {24'h0, vt[i].q});
            chk($sformatf("v%0d_remainder", i), {24'h0, r}, {24'h0, vt[i].r});
            chk($sformatf("v%0d_div_by_zero", i), {31'h0, dbz}, {31'h0, vt[i].dbz});
            chk($sformatf("v%0d_overflow", i), {31'h0, ovf}, {31'h0, vt[i].ovf});
        end

        // Start held for 40 cycles: one result, then a fresh rise is needed.
        dividend = 16'h0028; divisor = 8'hFB; start = 1'b1; pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done) pulses++;
        end
        chk("held_done_pulses", pulses, 1);
        chk("held_busy_in_hold", {31'h0, busy}, 32'h1);
        start = 1'b0;
        @(negedge clock);
        chk("held_release_idle", {31'h0, busy}, 32'h0);
        dividend = 16'h0064; divisor = 8'h07; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("held_reaccept_busy", {31'h0, busy}, 32'h1);
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            if (done) begin lat = c; break; end
            @(negedge clock);
        end
        chk("held_reaccept_latency", lat, 19);
        chk("held_reaccept_quotient", {24'h0, quotient}, 32'h0E);
        repeat (2) @(negedge clock);

        // Overflow flag clears on acceptance while the old quotient holds until DONE.
        run_op(16'h8000, 8'hFF, lat, q, r, dbz, ovf);
        chk("clr_prev_overflow", {31'h0, ovf}, 32'h1);
        dividend = 16'h0064; divisor = 8'h07; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("clr_overflow_on_accept", {31'h0, overflow}, 32'h0);
        chk("clr_quotient_holds", {24'h0, quotient}, 32'h80);
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            if (done) begin lat = c; break; end
            @(negedge clock);
        end
        chk("clr_latency", lat, 19);
        chk("clr_quotient", {24'h0, quotient}, 32'h0E);
        chk("clr_remainder", {24'h0, remainder}, 32'h02);
        repeat (2) @(negedge clock);

        // Reset at cycle 10 of an operation aborts it without a done pulse.
        dividend = 16'h0028; divisor = 8'hFB; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("midrst_quotient", {24'h0, quotient}, 32'h0);
        chk("midrst_remainder", {24'h0, remainder}, 32'h0);
        chk("midrst_ctrl", {28'h0, done, busy, div_by_zero, overflow}, 32'h0);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clock);
            if (done) pulses++;
        end
        chk("midrst_no_done", pulses, 0);
        run_op(16'h0028, 8'hFB, lat, q, r, dbz, ovf);
        chk("midrst_next_latency", lat, 19);
        chk("midrst_next_quotient", {24'h0, q}, 32'hF8);
        chk("midrst_next_remainder", {24'h0, r}, 32'h00);
        chk("midrst_next_flags", {30'h0, dbz, ovf}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/sdiv.md
SDIV -- requirements
Module: sdiv

Interface
REQ-001 The block SHALL have exactly one clock; reset is synchronous and active-high.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high; sampled on a rising clock edge.
REQ-004 start  input  1  level request, synchronous to clock; qualified only in IDLE.
REQ-005 dividend  input  16  two's-complement dividend; sampled when start is accepted.
REQ-006 divisor  input  8  two's-complement divisor; sampled when start is accepted.
REQ-007 quotient  output  8  two's-complement quotient; registered.
REQ-008 remainder  output  8  two's-complement remainder; registered.
REQ-009 done  output  1  one-cycle pulse marking that the results are valid.
REQ-010 busy  output  1  high in every state other than IDLE.
REQ-011 div_by_zero  output  1  sticky status for the last operation; divisor was 0.
REQ-012 overflow  output  1  sticky status for the last operation; quotient does not fit in 8 bits signed.

Function
REQ-013 The block SHALL implement the states IDLE, INIT, ITER, FIX, DONE and HOLD.
REQ-014 Transitions SHALL be as follows.
- IDLE goes to INIT on start=1; operands are latched on that edge (cycle 0).
- INIT goes to DONE if divisor=0, else to ITER.
- ITER runs exactly 16 cycles, counted by a mod-16 counter cleared in INIT, then goes to FIX.
- FIX goes to DONE.
- DONE goes to HOLD.
- HOLD goes to IDLE when start=0.
REQ-015 INIT SHALL form the operand magnitudes: |dividend| as 16-bit unsigned (0x8000 yields 32768), |divisor| as 8-bit unsigned (0x80 yields 128). INIT SHALL record the result signs: quotient sign = dividend sign XOR divisor sign; remainder sign = dividend sign.
REQ-016 Each ITER cycle SHALL perform one restoring step.
- Shift the {partial remainder, dividend} pair left by 1.
- Trial-subtract the divisor magnitude using a 9-bit partial remainder.
- If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set the bit to 0.
REQ-017 FIX SHALL negate the quotient and remainder magnitudes as the recorded signs require. Remainder magnitude is always less than |divisor|.
REQ-018 overflow SHALL be set in FIX when either condition holds: the signed result is positive and the quotient magnitude exceeds 127, or the signed result is negative and the quotient magnitude exceeds 128.
REQ-019 On overflow, the outputs SHALL be quotient=0x80 and remainder=0x00.
REQ-020 On divide-by-zero, the outputs SHALL be quotient=0x00, remainder=0x00, div_by_zero=1, overflow=0.
REQ-021 done SHALL be high only in DONE.
- Nonzero divisor: done on cycle 19 after acceptance.
- Zero divisor: done on cycle 2 after acceptance.
REQ-022 quotient, remainder, div_by_zero and overflow SHALL update only on the edge entering DONE. They hold until the next operation's DONE.
REQ-023 The status flags SHALL be cleared when a new start is accepted.
REQ-024 start SHALL be ignored while busy=1. A start held high through DONE SHALL NOT launch a second operation; HOLD requires start=0 before the block accepts again.
REQ-025 Changes on dividend or divisor after acceptance SHALL NOT affect the result.

Reset
REQ-026 When reset=1 at a clock edge, the following SHALL take effect:
- state=IDLE;
- counter=0;
- quotient=0x00 and remainder=0x00;
- done=0, busy=0, div_by_zero=0, overflow=0.
REQ-027 Reset SHALL take priority over start and over any in-progress operation. A reset in mid-ITER aborts with no done pulse.

Structure
REQ-028 Package sdiv_pkg SHALL hold:
- the state enumeration;
- DIVIDEND_W=16, DIVISOR_W=8, RESULT_W=8;
- ITER_COUNT=16.
REQ-029 The block SHALL be split into a controller (state machine, counter, done/busy) and one sub-module, sdiv_datapath. sdiv_datapath holds the operand registers, shift/subtract logic, sign fix and flag logic, and is steered by the controller's control bits.

Verification
REQ-030 dividend=0x0028, divisor=0xFB -> quotient=0xF8, remainder=0x00, flags 0; done on cycle 19.
REQ-031 dividend=0xFFD9, divisor=0x07 -> quotient=0xFB, remainder=0xFC, flags 0.
REQ-032 dividend=0xFF80, divisor=0x01 -> quotient=0x80, overflow=0. dividend=0x8000, divisor=0xFF -> overflow=1, quotient=0x80, remainder=0x00.
REQ-033 dividend=0x1234, divisor=0x00 -> div_by_zero=1, quotient=0x00, remainder=0x00; done on cycle 2.
REQ-034 start held high for 40 cycles -> exactly one done pulse; a second operation is accepted only after start returns to 0 and then rises.
REQ-035 reset=1 asserted at cycle 10 of an operation -> all outputs reset on the next edge, no done pulse; a following operation with dividend=0x0028, divisor=0xFB completes correctly.
